axil_rd_arbiter: RTL and testbench
==================================

# axil_rd_arbiter

Two-master round-robin arbiter for the AXI4-Lite read channels in front of a single AXI-Lite read slave (the snapshot BRAM read port). It lets the PS general-purpose port and a second on-fabric read master (e.g. a DMA/readout sequencer) share one read-only register/BRAM window. One transaction is in flight at a time. The address is registered, and the read-data channel is routed back to the granted master.

## Interface
Parameters:
- DATA_WIDTH, 32, read data width
- ADDR_WIDTH, 10, word-address width of the downstream RAM; the byte address is ADDR_WIDTH+2 bits

Ports:
- axi_clock  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s0_araddr  in  ADDR_WIDTH+2  master 0 byte address
- s0_arvalid  in  1  master 0 address valid
- s0_arready  out  1  master 0 address accepted
- s0_arprot  in  3  master 0 protection bits
- s0_rdata  out  DATA_WIDTH  master 0 read data
- s0_rresp  out  2  master 0 response
- s0_rvalid  out  1  master 0 data valid
- s0_rready  in  1  master 0 data ready
- s1_*  same set as s0_*, for master 1
- m_araddr  out  ADDR_WIDTH+2  downstream address
- m_arvalid  out  1  downstream address valid
- m_arready  in  1  downstream address ready
- m_arprot  out  3  downstream protection bits
- m_rdata  in  DATA_WIDTH  downstream data
- m_rresp  in  2  downstream response
- m_rvalid  in  1  downstream data valid
- m_rready  out  1  downstream data ready
- grant  out  1  index of the master owning the current/last transaction
- busy  out  1  high in ADDR or DATA state

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE**
  - Arbitration is combinational over s0_arvalid and s1_arvalid.
  - If only one master requests, that master wins.
  - If both request, the winner is the master that is not `last`.
  - s_arready of the winner only is driven high combinationally in IDLE.
  - On the handshake: latch araddr, arprot and the winner into the `gnt` register, then go to ADDR.
- **ADDR**
  - m_arvalid=1, m_araddr/m_arprot come from the registers.
  - Every s*_arready is 0.
  - On m_arvalid&&m_arready, go to DATA.
- **DATA**
  - s{gnt}_rvalid=m_rvalid, s{gnt}_rdata=m_rdata, s{gnt}_rresp=m_rresp, m_rready=s{gnt}_rready.
  - The non-granted master sees rvalid=0.
  - On m_rvalid&&m_rready: last<=gnt, go to IDLE.
- Outside DATA: m_rready=0 and every s*_rvalid=0; any m_rvalid is ignored, because the downstream never issues unsolicited data.
- araddr is forwarded unmodified (byte address). Downstream drops bits [1:0].
- **Stall:** if the granted master holds rready low, the FSM stays in DATA. rdata stability is the downstream skid buffer's responsibility, since the data path is pass-through.
- A request from the losing master stays pending (arready=0) until the FSM returns to IDLE.

## Timing
- **Reset values:**
  - state=IDLE, last=1 (master 0 has first priority), gnt=0, grant=0, busy=0.
  - Address/prot registers are 0.
  - All s*_arready, s*_rvalid, m_arvalid and m_rready are 0.
- **Cycle numbering (one transaction):**
  - Cycle 0: accept, with arvalid&&arready in IDLE.
  - Cycle 1: m_arvalid first high.
  - Cycle 1+a: DATA is entered, where a ≥ 1 is the number of cycles until m_arready.
  - Completion: the first cycle in DATA where m_rvalid&&m_rready holds.
  - The next accept is possible the cycle after completion.
  - Minimum spacing between accepts is 3 cycles plus the downstream latency.
- **Simultaneous events:**
  - Both masters raising arvalid in the same IDLE cycle resolves by `last`; ties never stall.
  - A new arvalid arriving in the completion cycle is not accepted in that cycle.
- **Reset mid-operation:** rst in ADDR or DATA forces IDLE next cycle and drops every valid/ready output at once. The downstream slave shares rst, so no orphaned response remains.
- grant and busy are registered, with no combinational path from inputs.

## Structure
- Shared header `axil_defs.vh` holds:
  - the FSM state localparams (IDLE=2'd0, ADDR=2'd1, DATA=2'd2);
  - the AXI response codes (OKAY=2'b00, SLVERR=2'b10), which are reused by the other AXI-Lite blocks.
- One natural sub-module, `rr_arb2`:
  - a combinational two-requester round-robin pick from req[1:0] and `last`;
  - outputs `valid` and `idx`.
- The FSM, registers and muxing live in the top level.

## Test plan
- **Single read:** s0 reads 0x008, RAM word 2 = 0xDEADBEEF, m_arready always high. Required: s0_arready in cycle 0, m_araddr=0x008 in cycle 1, s0_rdata=0xDEADBEEF with rresp=00, s1_rvalid never high.
- **Contention after reset:** s0 and s1 assert arvalid in the same cycle. Required: s0 is served first, s1 second, then strict alternation over 8 back-to-back requests per master (grant sequence 0,1,0,1,…).
- **Back-to-back single master:** s1 only, addresses 0x000…0x01C. Required: all 8 are served in order with correct data, and accepts are spaced at least 3 cycles plus latency apart.
- **Read-data stall:** s0 holds rready low for 5 cycles after rvalid. Required: m_rready stays 0, busy=1, rdata is stable throughout, s1 is not granted until the beat completes.
- **Downstream address stall:** m_arready held low for 4 cycles. Required: m_arvalid and m_araddr are stable, and both s*_arready stay 0.
- **Reset mid-DATA:** rst in DATA. Required: next cycle all valids and readies are 0, state is IDLE, grant=0, and a subsequent s0 read completes normally.

Source files
------------

// File: rtl/axil_rd_arbiter_pkg.sv
// Types and helpers shared by the AXI-Lite read arbiter and its round-robin picker.
package axil_rd_arbiter_pkg;
`include "axil_defs.vh"

  typedef logic [1:0] state_t;

  // With both requesting, the master that did not go last wins.
  function automatic logic pick_rr2(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction
endpackage

// File: rtl/axil_defs.vh
// Shared AXI-Lite read-path constants: arbiter FSM encoding and response codes.
`ifndef AXIL_DEFS_VH
`define AXIL_DEFS_VH
localparam logic [1:0] IDLE   = 2'd0;
localparam logic [1:0] ADDR   = 2'd1;
localparam logic [1:0] DATA   = 2'd2;
localparam logic [1:0] OKAY   = 2'b00;
localparam logic [1:0] SLVERR = 2'b10;
`endif

// File: rtl/axil_rd_arbiter_rr_arb2.sv
// Combinational two-requester round-robin pick.
module rr_arb2
  import axil_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);
  assign valid = |req;
  assign idx   = pick_rr2(req, last);
endmodule

// File: rtl/axil_rd_arbiter.sv
// Two-master round-robin arbiter for AXI-Lite read channels; one transaction in flight,
// registered address, read data routed combinationally back to the granted master.
module axil_rd_arbiter
  import axil_rd_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    axi_clock,
  input  logic                    rst,
  input  logic [ADDR_WIDTH+1:0]   s0_araddr,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  input  logic [2:0]              s0_arprot,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  input  logic [ADDR_WIDTH+1:0]   s1_araddr,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  input  logic [2:0]              s1_arprot,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  output logic [ADDR_WIDTH+1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [2:0]              m_arprot,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic                    grant,
  output logic                    busy
);
  state_t                state, state_nxt;
  logic                  gnt, last, busy_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [2:0]            prot_q;
  logic                  arb_valid, arb_idx;
  logic                  accept, in_addr, in_data, done;

  rr_arb2 u_arb (
    .req   ({s1_arvalid, s0_arvalid}),
    .last  (last),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Gating with rst drops every handshake output in the reset cycle itself.
  assign accept  = !rst && (state == IDLE) && arb_valid;
  assign in_addr = !rst && (state == ADDR);
  assign in_data = !rst && (state == DATA);
  assign done    = in_data && m_rvalid && m_rready;

  assign s0_arready = accept && !arb_idx;
  assign s1_arready = accept &&  arb_idx;

  assign m_arvalid = in_addr;
  assign m_araddr  = addr_q;
  assign m_arprot  = prot_q;

  assign m_rready  = in_data && (gnt ? s1_rready : s0_rready);
  assign s0_rvalid = in_data && !gnt && m_rvalid;
  assign s1_rvalid = in_data &&  gnt && m_rvalid;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;

  assign grant = gnt;
  assign busy  = busy_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ADDR;
      ADDR:    if (m_arvalid && m_arready) state_nxt = DATA;
      DATA:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      state  <= IDLE;
      last   <= 1'b1;
      gnt    <= 1'b0;
      addr_q <= '0;
      prot_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      if (accept) begin
        gnt    <= arb_idx;
        addr_q <= arb_idx ? s1_araddr : s0_araddr;
        prot_q <= arb_idx ? s1_arprot : s0_arprot;
      end
      if (done) last <= gnt;
    end
  end
endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Directed bench for axil_rd_arbiter with a behavioural downstream BRAM read slave.
`timescale 1ns/1ps
module tb_axil_rd_arbiter;
  import axil_rd_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = AW + 2;

  logic          axi_clock = 1'b0;
  logic          rst;
  logic [BW-1:0] s_araddr [2];
  logic          s_arvalid[2];
  logic [2:0]    s_arprot [2];
  logic          s_rready [2];
  logic          s0_arready, s1_arready, s0_rvalid, s1_rvalid;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [1:0]    s0_rresp, s1_rresp;
  logic [BW-1:0] m_araddr;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [2:0]    m_arprot;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          grant, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 axi_clock = ~axi_clock;

  axil_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .axi_clock (axi_clock), .rst (rst),
    .s0_araddr (s_araddr[0]), .s0_arvalid (s_arvalid[0]), .s0_arready (s0_arready),
    .s0_arprot (s_arprot[0]), .s0_rdata (s0_rdata), .s0_rresp (s0_rresp),
    .s0_rvalid (s0_rvalid), .s0_rready (s_rready[0]),
    .s1_araddr (s_araddr[1]), .s1_arvalid (s_arvalid[1]), .s1_arready (s1_arready),
    .s1_arprot (s_arprot[1]), .s1_rdata (s1_rdata), .s1_rresp (s1_rresp),
    .s1_rvalid (s1_rvalid), .s1_rready (s_rready[1]),
    .m_araddr (m_araddr), .m_arvalid (m_arvalid), .m_arready (m_arready),
    .m_arprot (m_arprot), .m_rdata (m_rdata), .m_rresp (m_rresp),
    .m_rvalid (m_rvalid), .m_rready (m_rready),
    .grant (grant), .busy (busy)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM contents: word at byte address a holds C0DE_0aaa, except word 2.
  function automatic logic [31:0] exp_word(input logic [BW-1:0] a);
    return (a == 12'h008) ? 32'hDEADBEEF : {16'hC0DE, 4'h0, a};
  endfunction

  // Downstream slave: accepts address, waits `lat` extra cycles, holds rvalid until rready.
  logic [31:0]   ram [1024];
  int            lat = 0;
  int            sl_cnt;
  logic          sl_pend;
  logic [BW-1:0] sl_addr;
  always @(posedge axi_clock) begin
    if (rst) begin
      sl_pend <= 1'b0; sl_cnt <= 0; sl_addr <= '0;
      m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= OKAY;
    end else begin
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        sl_addr <= m_araddr; sl_cnt <= lat; sl_pend <= 1'b1;
      end else if (sl_pend) begin
        if (sl_cnt == 0) begin
          m_rvalid <= 1'b1; m_rdata <= ram[sl_addr[BW-1:2]]; m_rresp <= OKAY; sl_pend <= 1'b0;
        end else sl_cnt <= sl_cnt - 1;
      end
    end
  end

  int cyc = 0;
  int acc_idx_q[$];
  int acc_cyc_q[$];
  int s1_rv_cnt = 0;
  always @(posedge axi_clock) begin
    cyc <= cyc + 1;
    if (s_arvalid[0] && s0_arready) begin acc_idx_q.push_back(0); acc_cyc_q.push_back(cyc); end
    if (s_arvalid[1] && s1_arready) begin acc_idx_q.push_back(1); acc_cyc_q.push_back(cyc); end
    if (s1_rvalid) s1_rv_cnt <= s1_rv_cnt + 1;
  end

  // Entered at a falling edge with arvalid raised; leaves at the falling edge after accept.
  task automatic wait_arready(input int m, input string tag);
    int n;
    for (n = 0; n < 50; n++) begin
      #1;
      if ((m == 0) ? s0_arready : s1_arready) break;
      @(negedge axi_clock);
    end
    if (n == 50) expect_eq({tag, "_arready_timeout"}, 0, 1);
    @(posedge axi_clock);
    @(negedge axi_clock);
    s_arvalid[m] = 1'b0;
  endtask

  // Waits for the read beat, checks it, leaves at the falling edge after completion.
  task automatic wait_rvalid(input int m, input logic [BW-1:0] a, input string tag);
    int n;
    for (n = 0; n < 50; n++) begin
      #1;
      if ((m == 0) ? s0_rvalid : s1_rvalid) break;
      @(negedge axi_clock);
    end
    if (n == 50) expect_eq({tag, "_rvalid_timeout"}, 0, 1);
    else begin
      expect_eq({tag, "_rdata"}, (m == 0) ? s0_rdata : s1_rdata, exp_word(a));
      expect_eq({tag, "_rresp"}, (m == 0) ? s0_rresp : s1_rresp, OKAY);
    end
    @(posedge axi_clock);
    @(negedge axi_clock);
  endtask

  task automatic mread(input int m, input logic [BW-1:0] a, input string tag);
    s_araddr[m]  = a;
    s_arvalid[m] = 1'b1;
    wait_arready(m, tag);
    wait_rvalid(m, a, tag);
  endtask

  task automatic do_reset();
    @(negedge axi_clock);
    rst = 1'b1;
    repeat (2) @(negedge axi_clock);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int q0, n, rv0;
    logic [DW-1:0] held;
    for (int i = 0; i < 1024; i++) ram[i] = exp_word(BW'(i * 4));
    rst = 1'b1; m_arready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_arvalid[i] = 1'b0; s_araddr[i] = '0; s_arprot[i] = '0; s_rready[i] = 1'b1;
    end
    repeat (3) @(negedge axi_clock);
    #1;
    expect_eq("rst_s0_arready", s0_arready, 0);
    expect_eq("rst_s1_arready", s1_arready, 0);
    expect_eq("rst_m_arvalid", m_arvalid, 0);
    expect_eq("rst_m_rready", m_rready, 0);
    expect_eq("rst_rvalids", {s0_rvalid, s1_rvalid}, 0);
    expect_eq("rst_grant", grant, 0);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_m_araddr", m_araddr, 0);
    expect_eq("rst_m_arprot", m_arprot, 0);
    @(negedge axi_clock);
    rst = 1'b0;

    // Single read with cycle-exact checks.
    @(negedge axi_clock);
    rv0 = s1_rv_cnt;
    s_araddr[0] = 12'h008; s_arvalid[0] = 1'b1;
    #1;
    expect_eq("t1_s0_arready_c0", s0_arready, 1);
    expect_eq("t1_s1_arready_c0", s1_arready, 0);
    @(posedge axi_clock);
    @(negedge axi_clock);
    s_arvalid[0] = 1'b0;
    #1;
    expect_eq("t1_m_arvalid_c1", m_arvalid, 1);
    expect_eq("t1_m_araddr_c1", m_araddr, 12'h008);
    expect_eq("t1_busy_c1", busy, 1);
    expect_eq("t1_s0_arready_c1", s0_arready, 0);
    @(negedge axi_clock);
    wait_rvalid(0, 12'h008, "t1");
    expect_eq("t1_busy_after", busy, 0);
    expect_eq("t1_s1_rvalid_never", s1_rv_cnt - rv0, 0);

    // Simultaneous requests after reset: s0 first, then strict alternation.
    do_reset();
    q0 = acc_idx_q.size();
    fork
      begin for (int i = 0; i < 8; i++) mread(0, BW'(32'h100 + i * 4), "t2_m0"); end
      begin for (int j = 0; j < 8; j++) mread(1, BW'(32'h200 + j * 4), "t2_m1"); end
    join
    expect_eq("t2_accept_count", acc_idx_q.size() - q0, 16);
    for (int k = 0; k < 16; k++)
      if (q0 + k < acc_idx_q.size())
        expect_eq($sformatf("t2_grant_seq_%0d", k), acc_idx_q[q0 + k], k % 2);

    // Back-to-back from s1 alone with one extra cycle of downstream latency.
    lat = 1;
    q0 = acc_cyc_q.size();
    for (int i = 0; i < 8; i++) mread(1, BW'(i * 4), "t3");
    for (int k = 1; k < 8; k++)
      if (q0 + k < acc_cyc_q.size())
        expect_eq($sformatf("t3_spacing_%0d", k),
                  (acc_cyc_q[q0 + k] - acc_cyc_q[q0 + k - 1]) >= 3 + lat, 1);
    lat = 0;

    // Read-data stall by s0 while s1 waits.
    s_rready[0] = 1'b0;
    s_araddr[0] = 12'h010; s_arvalid[0] = 1'b1;
    wait_arready(0, "t4");
    s_araddr[1] = 12'h020; s_arvalid[1] = 1'b1;
    for (n = 0; n < 50; n++) begin
      #1;
      if (s0_rvalid) break;
      @(negedge axi_clock);
    end
    if (n == 50) expect_eq("t4_rvalid_timeout", 0, 1);
    held = s0_rdata;
    expect_eq("t4_rdata_first", held, exp_word(12'h010));
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge axi_clock); #1; end
      expect_eq($sformatf("t4_m_rready_%0d", k), m_rready, 0);
      expect_eq($sformatf("t4_busy_%0d", k), busy, 1);
      expect_eq($sformatf("t4_rdata_stable_%0d", k), s0_rdata, held);
      expect_eq($sformatf("t4_s1_arready_%0d", k), s1_arready, 0);
      expect_eq($sformatf("t4_grant_%0d", k), grant, 0);
    end
    @(negedge axi_clock);
    s_rready[0] = 1'b1;
    #1;
    expect_eq("t4_m_rready_release", m_rready, 1);
    @(posedge axi_clock);
    @(negedge axi_clock);
    wait_arready(1, "t4_s1");
    wait_rvalid(1, 12'h020, "t4_s1");
    expect_eq("t4_grant_s1", grant, 1);

    // Downstream address stall with s1 pending.
    m_arready = 1'b0;
    s_arprot[0] = 3'b101;
    s_araddr[0] = 12'h014; s_arvalid[0] = 1'b1;
    wait_arready(0, "t5");
    s_araddr[1] = 12'h018; s_arvalid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      expect_eq($sformatf("t5_m_arvalid_%0d", k), m_arvalid, 1);
      expect_eq($sformatf("t5_m_araddr_%0d", k), m_araddr, 12'h014);
      expect_eq($sformatf("t5_m_arprot_%0d", k), m_arprot, 3'b101);
      expect_eq($sformatf("t5_arready_%0d", k), {s0_arready, s1_arready}, 0);
      @(negedge axi_clock);
    end
    m_arready = 1'b1;
    wait_rvalid(0, 12'h014, "t5_s0");
    wait_arready(1, "t5_s1");
    wait_rvalid(1, 12'h018, "t5_s1");

    // Reset while s1 owns the DATA phase.
    s_rready[1] = 1'b0;
    s_araddr[1] = 12'h00C; s_arvalid[1] = 1'b1;
    wait_arready(1, "t6");
    for (n = 0; n < 50; n++) begin
      #1;
      if (s1_rvalid) break;
      @(negedge axi_clock);
    end
    if (n == 50) expect_eq("t6_rvalid_timeout", 0, 1);
    expect_eq("t6_grant_before", grant, 1);
    @(negedge axi_clock);
    rst = 1'b1;
    #1;
    expect_eq("t6_s1_rvalid_in_rst", s1_rvalid, 0);
    @(posedge axi_clock);
    @(negedge axi_clock);
    rst = 1'b0; s_rready[1] = 1'b1;
    #1;
    expect_eq("t6_m_arvalid", m_arvalid, 0);
    expect_eq("t6_m_rready", m_rready, 0);
    expect_eq("t6_rvalids", {s0_rvalid, s1_rvalid}, 0);
    expect_eq("t6_arreadys", {s0_arready, s1_arready}, 0);
    expect_eq("t6_busy", busy, 0);
    expect_eq("t6_grant", grant, 0);
    @(negedge axi_clock);
    s_araddr[0] = 12'h008; s_arvalid[0] = 1'b1;
    #1;
    expect_eq("t6_idle_arready", s0_arready, 1);
    wait_arready(0, "t6_s0");
    wait_rvalid(0, 12'h008, "t6_s0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
